// File: rtl/cpu_trace_pkg.sv
// Shared types for the cpu_6s46 instruction-trace buffer.
//
// trace_entry_t is one snapshot of architectural state plus the instruction's cycle length.
// Packed MSB..LSB as {[change_mask], cycles, flags, sp, y, x, b, a, pc}.
//
// Build option: define TRACE_CHANGE_MASK_EN to prepend a 6-bit change_mask
// {pc,a,b,xy,sp,flags} to every entry (ENTRY_W grows by 6).
package cpu_trace_pkg;

  // Width of the cycles field stored in each entry.
  localparam int unsigned TRACE_CYCLE_W = 8;

  typedef enum logic {
    TRACE_STOP = 1'b0,
    TRACE_RING = 1'b1
  } trace_mode_e;

  typedef struct packed {
`ifdef TRACE_CHANGE_MASK_EN
    logic [5:0]               change_mask;
`endif
    logic [TRACE_CYCLE_W-1:0] cycles;
    logic [3:0]               flags;
    logic [7:0]               sp;
    logic [11:0]              y;
    logic [11:0]              x;
    logic [3:0]               b;
    logic [3:0]               a;
    logic [12:0]              pc;
  } trace_entry_t;

  localparam int unsigned ENTRY_W = $bits(trace_entry_t);

  // Bit positions inside change_mask.
  localparam int unsigned MASK_PC    = 5;
  localparam int unsigned MASK_A     = 4;
  localparam int unsigned MASK_B     = 3;
  localparam int unsigned MASK_XY    = 2;
  localparam int unsigned MASK_SP    = 1;
  localparam int unsigned MASK_FLAGS = 0;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with first-word-fall-through head output.
//
// Ports:
//   clk, reset_n (sync, active-low), clear (sync flush)
//   push/wdata  - write request and data
//   pop         - read request; ignored while empty
//   rdata       - head entry, all-zero while empty
//   full/empty/count - occupancy status
//
// With OVERWRITE set, a push into a full FIFO without a simultaneous pop
// replaces the oldest entry (head advances, count stays DEPTH).
module trace_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned WIDTH     = 8,
  parameter bit          OVERWRITE = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_pop, do_write, do_overwrite;

  assign full  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  assign do_pop       = pop & ~empty;
  assign do_write     = push & (~full | do_pop | OVERWRITE);
  // Full, no pop: the write lands on the oldest slot, so the head must move too.
  assign do_overwrite = push & full & ~do_pop & OVERWRITE;

  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_write) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop || do_overwrite) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (do_write && !do_pop && !do_overwrite) begin
        count_q <= count_q + (PTR_W + 1)'(1);
      end else if (do_pop && !do_write) begin
        count_q <= count_q - (PTR_W + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Instruction-trace capture for cpu_6s46.
//
// Snapshots {pc,a,b,x,y,sp,flags} and the instruction's cycle length each time the
// microcode finishes an instruction, queues the snapshots in a DEPTH-entry FIFO and
// presents them on a valid/ready stream.
//
// Ports:
//   clk, reset_n (sync, active-low), clk_en (CPU cycle enable)
//   step_done, halt      - microcode is_last_cycle_step / halt
//   enable, clear        - capture enable, synchronous flush
//   pc,a,b,x,y,sp,flags  - architectural state tapped from the core
//   trace_valid/ready/data - head-of-queue stream (data is a cpu_trace_pkg::trace_entry_t)
//   count, overflow, drop_count - occupancy and loss statistics
//
// MODE 0 (TRACE_STOP) drops new entries when full; MODE 1 (TRACE_RING) overwrites the oldest.
// Build option: TRACE_CHANGE_MASK_EN adds a per-entry change_mask against the previous capture.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned CYCLE_W = 8,
  parameter int unsigned MODE    = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clk_en,
  input  logic                   step_done,
  input  logic                   halt,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [12:0]            pc,
  input  logic [3:0]             a,
  input  logic [3:0]             b,
  input  logic [11:0]            x,
  input  logic [11:0]            y,
  input  logic [7:0]             sp,
  input  logic [3:0]             flags,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [ENTRY_W-1:0]     trace_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [7:0]             drop_count
);

  localparam trace_mode_e MODE_E = trace_mode_e'(MODE[0]);
  localparam bit          RING   = (MODE_E == TRACE_RING);

  // Per-instruction cycle counter.
  logic [CYCLE_W-1:0]       cyc_q, cyc_d, cyc_inc;
  logic [TRACE_CYCLE_W-1:0] len_field;
  logic                     advance, done, capture;

  assign advance = clk_en & ~halt;
  assign done    = advance & step_done;
  assign capture = done & enable;
  // Saturating counter+1; this is both the next count and the stored length.
  assign cyc_inc = (&cyc_q) ? cyc_q : cyc_q + CYCLE_W'(1);

  always_comb begin
    cyc_d = cyc_q;
    if (done) begin
      cyc_d = '0;
    end else if (advance) begin
      cyc_d = cyc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  // Fit the counter into the entry's cycles field, saturating if the counter is wider.
  if (CYCLE_W > TRACE_CYCLE_W) begin : g_len_sat
    assign len_field = (|cyc_inc[CYCLE_W-1:TRACE_CYCLE_W]) ? '1
                                                           : cyc_inc[TRACE_CYCLE_W-1:0];
  end else begin : g_len_ext
    assign len_field = TRACE_CYCLE_W'(cyc_inc);
  end

`ifdef TRACE_CHANGE_MASK_EN
  logic [12:0] prev_pc_q;
  logic [3:0]  prev_a_q, prev_b_q, prev_flags_q;
  logic [11:0] prev_x_q, prev_y_q;
  logic [7:0]  prev_sp_q;
  logic [5:0]  change_mask;

  always_comb begin
    change_mask             = '0;
    // Sequential flow (pc advancing by one) is not reported as a pc change.
    change_mask[MASK_PC]    = (pc != prev_pc_q + 13'd1);
    change_mask[MASK_A]     = (a != prev_a_q);
    change_mask[MASK_B]     = (b != prev_b_q);
    change_mask[MASK_XY]    = (x != prev_x_q) || (y != prev_y_q);
    change_mask[MASK_SP]    = (sp != prev_sp_q);
    change_mask[MASK_FLAGS] = (flags != prev_flags_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      prev_pc_q    <= '0;
      prev_a_q     <= '0;
      prev_b_q     <= '0;
      prev_x_q     <= '0;
      prev_y_q     <= '0;
      prev_sp_q    <= '0;
      prev_flags_q <= '0;
    end else if (capture) begin
      prev_pc_q    <= pc;
      prev_a_q     <= a;
      prev_b_q     <= b;
      prev_x_q     <= x;
      prev_y_q     <= y;
      prev_sp_q    <= sp;
      prev_flags_q <= flags;
    end
  end
`endif

  trace_entry_t entry;

  always_comb begin
    entry        = '0;
    entry.pc     = pc;
    entry.a      = a;
    entry.b      = b;
    entry.x      = x;
    entry.y      = y;
    entry.sp     = sp;
    entry.flags  = flags;
    entry.cycles = len_field;
`ifdef TRACE_CHANGE_MASK_EN
    entry.change_mask = change_mask;
`endif
  end

  logic fifo_full, fifo_empty, pop, lost;

  assign trace_valid = ~fifo_empty;
  assign pop         = trace_valid & trace_ready;
  // Full with no pop loses an entry in both modes: the new one (stop) or the oldest (ring).
  assign lost        = capture & fifo_full & ~pop;

  trace_fifo #(
    .DEPTH     (DEPTH),
    .WIDTH     (ENTRY_W),
    .OVERWRITE (RING)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (capture),
    .wdata   (entry),
    .pop     (pop),
    .rdata   (trace_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (lost) begin
      overflow   <= 1'b1;
      drop_count <= sat_inc8(drop_count);
    end
  end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
module tb_cpu_trace_buffer;
  import cpu_trace_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, clk_en, step_done, halt, enable, clear;
  logic [12:0] pc;
  logic [3:0]  a, b, flags;
  logic [11:0] x, y;
  logic [7:0]  sp;

  logic               ready_s, ready_r, valid_s, valid_r, ovf_s, ovf_r;
  logic [ENTRY_W-1:0] data_s, data_r;
  logic [2:0]         count_s, count_r;
  logic [7:0]         drop_s, drop_r;
  trace_entry_t       head_s, head_r;

  assign head_s = trace_entry_t'(data_s);
  assign head_r = trace_entry_t'(data_r);

  cpu_trace_buffer #(.DEPTH(DEPTH), .CYCLE_W(8), .MODE(0)) u_stop (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .step_done(step_done), .halt(halt),
    .enable(enable), .clear(clear), .pc(pc), .a(a), .b(b), .x(x), .y(y), .sp(sp),
    .flags(flags), .trace_valid(valid_s), .trace_ready(ready_s), .trace_data(data_s),
    .count(count_s), .overflow(ovf_s), .drop_count(drop_s)
  );

  cpu_trace_buffer #(.DEPTH(DEPTH), .CYCLE_W(8), .MODE(1)) u_ring (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .step_done(step_done), .halt(halt),
    .enable(enable), .clear(clear), .pc(pc), .a(a), .b(b), .x(x), .y(y), .sp(sp),
    .flags(flags), .trace_valid(valid_r), .trace_ready(ready_r), .trace_data(data_r),
    .count(count_r), .overflow(ovf_r), .drop_count(drop_r)
  );

  int checks   = 0;
  int failures = 0;

  // Scoreboards: expected contents of each DUT's queue, oldest first.
  trace_entry_t q_s[$];
  trace_entry_t q_r[$];
  int           m_cnt;
  logic [12:0]  m_prev_pc;
  logic [3:0]   m_prev_a, m_prev_b, m_prev_flags;
  logic [11:0]  m_prev_x, m_prev_y;
  logic [7:0]   m_prev_sp;

  function automatic trace_entry_t make_entry(input int len);
    trace_entry_t e;
    e        = '0;
    e.pc     = pc;
    e.a      = a;
    e.b      = b;
    e.x      = x;
    e.y      = y;
    e.sp     = sp;
    e.flags  = flags;
    e.cycles = 8'(len);
`ifdef TRACE_CHANGE_MASK_EN
    e.change_mask = {pc != m_prev_pc + 13'd1, a != m_prev_a, b != m_prev_b,
                     (x != m_prev_x) || (y != m_prev_y), sp != m_prev_sp, flags != m_prev_flags};
`endif
    return e;
  endfunction

  task automatic model_flush();
    q_s.delete();
    q_r.delete();
    m_cnt        = 0;
    m_prev_pc    = '0;
    m_prev_a     = '0;
    m_prev_b     = '0;
    m_prev_x     = '0;
    m_prev_y     = '0;
    m_prev_sp    = '0;
    m_prev_flags = '0;
  endtask

  task automatic set_regs(input logic [12:0] p, input logic [3:0] av, input logic [3:0] bv);
    pc    = p;
    a     = av;
    b     = bv;
    x     = 12'(p * 3);
    y     = 12'(p + 7);
    sp    = 8'(p);
    flags = 4'(p);
  endtask

  // One clock: drive inputs, compare heads being popped, update the model, advance.
  task automatic step(input bit ce, input bit sd, input bit hl, input bit rs, input bit rr);
    trace_entry_t e;
    int           len;
    bit           cap, pop_s, pop_r;
    clk_en    = ce;
    step_done = sd;
    halt      = hl;
    ready_s   = rs;
    ready_r   = rr;
    pop_s     = rs && (q_s.size() > 0);
    pop_r     = rr && (q_r.size() > 0);
    if (rs) begin
      checks++;
      if (valid_s !== (q_s.size() > 0)) begin
        failures++;
        $display("FAIL sb_valid_stop got=%0b exp=%0b", valid_s, q_s.size() > 0);
      end
      if (q_s.size() > 0) begin
        checks++;
        if (data_s !== q_s[0]) begin
          failures++;
          $display("FAIL sb_data_stop got=%0h exp=%0h", data_s, q_s[0]);
        end
      end
    end
    if (rr) begin
      checks++;
      if (valid_r !== (q_r.size() > 0)) begin
        failures++;
        $display("FAIL sb_valid_ring got=%0b exp=%0b", valid_r, q_r.size() > 0);
      end
      if (q_r.size() > 0) begin
        checks++;
        if (data_r !== q_r[0]) begin
          failures++;
          $display("FAIL sb_data_ring got=%0h exp=%0h", data_r, q_r[0]);
        end
      end
    end
    cap = 1'b0;
    if (ce && !hl) begin
      len = (m_cnt >= 255) ? 255 : m_cnt + 1;
      if (sd) begin
        m_cnt = 0;
        if (enable) begin
          cap          = 1'b1;
          e            = make_entry(len);
          m_prev_pc    = pc;
          m_prev_a     = a;
          m_prev_b     = b;
          m_prev_x     = x;
          m_prev_y     = y;
          m_prev_sp    = sp;
          m_prev_flags = flags;
        end
      end else begin
        m_cnt = len;
      end
    end
    if (pop_s) void'(q_s.pop_front());
    if (pop_r) void'(q_r.pop_front());
    if (cap) begin
      if (q_s.size() < DEPTH) q_s.push_back(e);
      if (q_r.size() == DEPTH) void'(q_r.pop_front());
      q_r.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Instruction of len clk_en cycles; halt cycles inserted after the first one.
  task automatic run_instr(input int len, input int halts);
    for (int i = 0; i < len; i++) begin
      if (i == 1) begin
        repeat (halts) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      step(1'b1, (i == len - 1), 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && (q_s.size() > 0 || q_r.size() > 0); i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    checks++;
    if (valid_s !== 1'b0 || valid_r !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty got=%0b%0b exp=00", valid_s, valid_r);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clk_en = 1'b0; step_done = 1'b0; halt = 1'b0; ready_s = 1'b0; ready_r = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_flush();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    clk_en = 1'b0; step_done = 1'b0; halt = 1'b0; ready_s = 1'b0; ready_r = 1'b0;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_flush();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (valid_s !== 1'b0 || valid_r !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%0b%0b exp=00", valid_s, valid_r);
    end
    checks++;
    if (count_s !== 3'd0 || count_r !== 3'd0) begin
      failures++; $display("FAIL reset_count got=%0d/%0d exp=0", count_s, count_r);
    end
    checks++;
    if (ovf_s !== 1'b0 || drop_s !== 8'd0 || ovf_r !== 1'b0 || drop_r !== 8'd0) begin
      failures++; $display("FAIL reset_stats got=%0b/%0d exp=0/0", ovf_s, drop_s);
    end
    checks++;
    if (data_s !== '0) begin
      failures++; $display("FAIL reset_data got=%0h exp=0", data_s);
    end
  endtask

  task automatic test_single_nop();
    do_reset();
    set_regs(13'h100, 4'h1, 4'h2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (valid_s !== 1'b0) begin
      failures++; $display("FAIL nop_early_valid got=%0b exp=0", valid_s);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (valid_s !== 1'b1 || count_s !== 3'd1) begin
      failures++; $display("FAIL nop_valid got=%0b/%0d exp=1/1", valid_s, count_s);
    end
    checks++;
    if (head_s.cycles !== 8'd3 || head_s.pc !== 13'h100) begin
      failures++; $display("FAIL nop_entry got=%0d@%0h exp=3@100", head_s.cycles, head_s.pc);
    end
    drain();
  endtask

  task automatic test_fill_modes();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      set_regs(13'(16 + i), 4'(i), 4'(i + 1));
      run_instr(2, 0);
    end
    checks++;
    if (count_s !== 3'd4 || count_r !== 3'd4) begin
      failures++; $display("FAIL fill_count got=%0d/%0d exp=4/4", count_s, count_r);
    end
    checks++;
    if (ovf_s !== 1'b1 || ovf_r !== 1'b1) begin
      failures++; $display("FAIL fill_overflow got=%0b%0b exp=11", ovf_s, ovf_r);
    end
    checks++;
    if (drop_s !== 8'd2 || drop_r !== 8'd2) begin
      failures++; $display("FAIL fill_drops got=%0d/%0d exp=2/2", drop_s, drop_r);
    end
    checks++;
    if (head_s.pc !== 13'h11 || head_r.pc !== 13'h13) begin
      failures++; $display("FAIL fill_heads got=%0h/%0h exp=11/13", head_s.pc, head_r.pc);
    end
    drain();
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      set_regs(13'(32 + i), 4'(i), 4'h0);
      run_instr(2, 0);
    end
    set_regs(13'h25, 4'h5, 4'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    checks++;
    if (count_s !== 3'd4 || count_r !== 3'd4) begin
      failures++; $display("FAIL pushpop_count got=%0d/%0d exp=4/4", count_s, count_r);
    end
    checks++;
    if (drop_s !== 8'd0 || drop_r !== 8'd0 || ovf_s !== 1'b0 || ovf_r !== 1'b0) begin
      failures++; $display("FAIL pushpop_drops got=%0d/%0d exp=0/0", drop_s, drop_r);
    end
    checks++;
    if (head_s.pc !== 13'h22 || head_r.pc !== 13'h22) begin
      failures++; $display("FAIL pushpop_head got=%0h/%0h exp=22/22", head_s.pc, head_r.pc);
    end
    drain();
  endtask

  task automatic test_halt_and_gate();
    do_reset();
    set_regs(13'h30, 4'h3, 4'h3);
    run_instr(3, 10);
    checks++;
    if (count_s !== 3'd1 || head_s.cycles !== 8'd3) begin
      failures++; $display("FAIL halt_cycles got=%0d/%0d exp=1/3", count_s, head_s.cycles);
    end
    drain();
    enable = 1'b0;
    run_instr(5, 0);
    enable = 1'b1;
    set_regs(13'h40, 4'h4, 4'h4);
    run_instr(2, 0);
    checks++;
    if (count_s !== 3'd1 || head_s.cycles !== 8'd2) begin
      failures++; $display("FAIL gated_cycles got=%0d/%0d exp=1/2", count_s, head_s.cycles);
    end
    drain();
    set_regs(13'h50, 4'h5, 4'h5);
    run_instr(300, 0);
    checks++;
    if (head_s.cycles !== 8'hff) begin
      failures++; $display("FAIL sat_cycles got=%0d exp=255", head_s.cycles);
    end
    drain();
  endtask

  task automatic test_clear_reset();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      set_regs(13'(96 + i), 4'(i), 4'h1);
      run_instr(2, 0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_clear();
    checks++;
    if (valid_s !== 1'b0 || count_s !== 3'd0 || ovf_s !== 1'b0 || drop_s !== 8'd0) begin
      failures++; $display("FAIL clear_stop got=%0b/%0d/%0b exp=0/0/0", valid_s, count_s, ovf_s);
    end
    checks++;
    if (valid_r !== 1'b0 || count_r !== 3'd0 || ovf_r !== 1'b0 || drop_r !== 8'd0) begin
      failures++; $display("FAIL clear_ring got=%0b/%0d/%0b exp=0/0/0", valid_r, count_r, ovf_r);
    end
    set_regs(13'h70, 4'h7, 4'h7);
    run_instr(2, 0);
    checks++;
    if (head_s.cycles !== 8'd2) begin
      failures++; $display("FAIL clear_counter got=%0d exp=2", head_s.cycles);
    end
    for (int i = 1; i <= 2; i++) run_instr(2, 0);
    do_reset();
    checks++;
    if (valid_s !== 1'b0 || count_s !== 3'd0 || valid_r !== 1'b0 || count_r !== 3'd0) begin
      failures++; $display("FAIL reset_flush got=%0d/%0d exp=0/0", count_s, count_r);
    end
  endtask

`ifdef TRACE_CHANGE_MASK_EN
  task automatic test_change_mask();
    do_reset();
    set_regs(13'h200, 4'h0, 4'h1);
    x = 12'h123; y = 12'h456; sp = 8'h80; flags = 4'h5;
    run_instr(2, 0);
    pc = 13'h201;
    a  = 4'h5;
    run_instr(2, 0);
    checks++;
    if (head_s.change_mask !== 6'b101111) begin
      failures++; $display("FAIL mask_first got=%b exp=101111", head_s.change_mask);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (head_s.change_mask !== 6'b010000) begin
      failures++; $display("FAIL mask_second got=%b exp=010000", head_s.change_mask);
    end
    drain();
  endtask
`endif

  initial begin
    reset_n = 1'b0; clear = 1'b0; enable = 1'b1;
    clk_en = 1'b0; step_done = 1'b0; halt = 1'b0; ready_s = 1'b0; ready_r = 1'b0;
    set_regs(13'h0, 4'h0, 4'h0);
    model_flush();
    test_reset();
    test_single_nop();
    test_fill_modes();
    test_full_push_pop();
    test_halt_and_gate();
    test_clear_reset();
`ifdef TRACE_CHANGE_MASK_EN
    test_change_mask();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
